// File: rtl/kulisch_mean_sequencer_if.sv
// Bundle of addend stream, shared-divider handshake and mean output stream
// seen by kulisch_mean_sequencer (slave) and its environment (master).
interface kulisch_mean_sequencer_if #(
  parameter int ACC_W     = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 inValid;
  logic                 inReady;
  logic [ACC_W-1:0]     inData;
  logic                 inLast;
  logic                 divStart;
  logic [ACC_W-1:0]     divAcc;
  logic [CNT_WIDTH-1:0] divDenom;
  logic                 divDone;
  logic [ACC_W-1:0]     divResult;
  logic                 outValid;
  logic                 outReady;
  logic [ACC_W-1:0]     outData;
  logic                 outForced;

  modport master (
    output inValid, inData, inLast, divDone, divResult, outReady,
    input  inReady, divStart, divAcc, divDenom, outValid, outData, outForced
  );

  modport slave (
    input  inValid, inData, inLast, divDone, divResult, outReady,
    output inReady, divStart, divAcc, divDenom, outValid, outData, outForced
  );
endinterface

// File: rtl/kulisch_mean_sequencer.sv
// Sums addend groups in a Kulisch accumulator and drives a shared divider to form the group mean.
// Optional KULISCH_MEAN_SEQ_BYPASS1_EN: single-item groups skip the divider.
module kulisch_mean_sequencer #(
  parameter int ACC_NON_FRAC = 8,
  parameter int ACC_FRAC     = 8,
  parameter int CNT_WIDTH    = 8
) (
  input logic                    clock_i,
  input logic                    reset_i,
  kulisch_mean_sequencer_if.slave bus
);
  localparam int ACC_W = ACC_NON_FRAC + ACC_FRAC;
  // A transfer while the counter sits here fills the group to 2^CNT_WIDTH-1 items.
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'((2 ** CNT_WIDTH) - 2);

  typedef enum logic [1:0] {ACCUM, DIV_REQ, DIV_WAIT, OUT} state_t;

  state_t               state_q;
  logic [ACC_W-1:0]     acc_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [ACC_W-1:0]     div_acc_q;
  logic [CNT_WIDTH-1:0] div_denom_q;
  logic                 div_start_q;
  logic [ACC_W-1:0]     out_data_q;
  logic                 out_valid_q;
  logic                 out_forced_q;

  logic                 transfer_d;
  logic                 close_d;
  logic [ACC_W-1:0]     sum_d;
  logic [CNT_WIDTH-1:0] count_inc_d;

  assign transfer_d  = bus.inValid && (state_q == ACCUM);
  assign close_d     = bus.inLast || (count_q == CNT_LIMIT);
  assign sum_d       = acc_q + bus.inData;
  assign count_inc_d = count_q + 1'b1;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      count_q      <= '0;
      div_acc_q    <= '0;
      div_denom_q  <= '0;
      div_start_q  <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_forced_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (transfer_d) begin
            if (close_d) begin
              div_acc_q    <= sum_d;
              div_denom_q  <= count_inc_d;
              out_forced_q <= !bus.inLast;
              acc_q        <= '0;
              count_q      <= '0;
`ifdef KULISCH_MEAN_SEQ_BYPASS1_EN
              // Mean of one item is the item itself; acc is zero here so sum_d == inData.
              if (count_q == '0) begin
                out_data_q  <= bus.inData;
                out_valid_q <= 1'b1;
                state_q     <= OUT;
              end else begin
                div_start_q <= 1'b1;
                state_q     <= DIV_REQ;
              end
`else
              div_start_q <= 1'b1;
              state_q     <= DIV_REQ;
`endif
            end else begin
              acc_q   <= sum_d;
              count_q <= count_inc_d;
            end
          end
        end
        DIV_REQ: begin
          div_start_q <= 1'b0;
          state_q     <= DIV_WAIT;
        end
        DIV_WAIT: begin
          if (bus.divDone) begin
            out_data_q  <= bus.divResult;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (bus.outReady) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.inReady   = (state_q == ACCUM);
  assign bus.divStart  = div_start_q;
  assign bus.divAcc    = div_acc_q;
  assign bus.divDenom  = div_denom_q;
  assign bus.outValid  = out_valid_q;
  assign bus.outData   = out_data_q;
  assign bus.outForced = out_forced_q;
endmodule

// File: tb/tb_kulisch_mean_sequencer.sv
// Directed bench for kulisch_mean_sequencer; the bench plays upstream, divider and consumer.
module tb_kulisch_mean_sequencer;
  logic clk;
  logic rst;
  int checks = 0;
  int passed = 0;
  int push_timeouts = 0;

  kulisch_mean_sequencer_if #(.ACC_W(16), .CNT_WIDTH(8)) bus ();

  kulisch_mean_sequencer #(.ACC_NON_FRAC(8), .ACC_FRAC(8), .CNT_WIDTH(8)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the addend was taken.
  task automatic push(input logic [15:0] d, input logic last);
    int n = 0;
    bus.inValid = 1'b1;
    bus.inData  = d;
    bus.inLast  = last;
    while (!bus.inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) push_timeouts++;
    @(negedge clk);
    bus.inValid = 1'b0;
    bus.inLast  = 1'b0;
  endtask

  task automatic wait_div(output int lat);
    lat = 0;
    while (!bus.divStart && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.divStart) lat = 999;
  endtask

  task automatic div_done(input logic [15:0] r);
    bus.divDone   = 1'b1;
    bus.divResult = r;
    @(negedge clk);
    bus.divDone   = 1'b0;
  endtask

  task automatic handshake();
    bus.outReady = 1'b1;
    @(negedge clk);
    bus.outReady = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.inReady !== 1'b1) $display("FAIL reset_inReady got %b want 1", bus.inReady); else passed++;
    checks++; if (bus.outValid !== 1'b0) $display("FAIL reset_outValid got %b want 0", bus.outValid); else passed++;
    checks++; if (bus.divStart !== 1'b0) $display("FAIL reset_divStart got %b want 0", bus.divStart); else passed++;
    checks++; if (bus.outForced !== 1'b0) $display("FAIL reset_outForced got %b want 0", bus.outForced); else passed++;
    checks++; if ({bus.divAcc, bus.divDenom, bus.outData} !== 40'h0) $display("FAIL reset_regs got %h want 0", {bus.divAcc, bus.divDenom, bus.outData}); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int lat;
    push(16'h0100, 1'b0);
    push(16'h0200, 1'b0);
    push(16'h0300, 1'b1);
    wait_div(lat);
    checks++; if (lat !== 0) $display("FAIL basic_latency got %0d want 0", lat); else passed++;
    checks++; if (bus.divAcc !== 16'h0600) $display("FAIL basic_divAcc got %h want 0600", bus.divAcc); else passed++;
    checks++; if (bus.divDenom !== 8'd3) $display("FAIL basic_divDenom got %0d want 3", bus.divDenom); else passed++;
    @(negedge clk);
    checks++; if (bus.divStart !== 1'b0) $display("FAIL basic_divStart_pulse got %b want 0", bus.divStart); else passed++;
    checks++; if (bus.inReady !== 1'b0) $display("FAIL basic_inReady_wait got %b want 0", bus.inReady); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (bus.divAcc !== 16'h0600) $display("FAIL basic_divAcc_stable got %h want 0600", bus.divAcc); else passed++;
    div_done(16'h0200);
    checks++; if (bus.outValid !== 1'b1) $display("FAIL basic_outValid got %b want 1", bus.outValid); else passed++;
    checks++; if (bus.outData !== 16'h0200) $display("FAIL basic_outData got %h want 0200", bus.outData); else passed++;
    checks++; if (bus.outForced !== 1'b0) $display("FAIL basic_outForced got %b want 0", bus.outForced); else passed++;
    handshake();
    checks++; if (bus.outValid !== 1'b0) $display("FAIL basic_outValid_clr got %b want 0", bus.outValid); else passed++;
    checks++; if (bus.inReady !== 1'b1) $display("FAIL basic_inReady_back got %b want 1", bus.inReady); else passed++;
    $display("test_basic done");
  endtask

  task automatic test_signed_wrap();
    int lat;
    push(16'hFF00, 1'b0);
    push(16'hFF00, 1'b1);
    wait_div(lat);
    checks++; if (bus.divAcc !== 16'hFE00) $display("FAIL neg_divAcc got %h want FE00", bus.divAcc); else passed++;
    checks++; if (bus.divDenom !== 8'd2) $display("FAIL neg_divDenom got %0d want 2", bus.divDenom); else passed++;
    @(negedge clk);
    div_done(16'hFF00);
    checks++; if (bus.outData !== 16'hFF00) $display("FAIL neg_outData got %h want FF00", bus.outData); else passed++;
    handshake();
    push(16'h7F00, 1'b0);
    push(16'h0200, 1'b1);
    wait_div(lat);
    checks++; if (bus.divAcc !== 16'h8100) $display("FAIL wrap_divAcc got %h want 8100", bus.divAcc); else passed++;
    @(negedge clk);
    div_done(16'hC080);
    checks++; if (bus.outData !== 16'hC080) $display("FAIL wrap_outData got %h want C080", bus.outData); else passed++;
    handshake();
    $display("test_signed_wrap done");
  endtask

  task automatic test_forced();
    int lat;
    for (int i = 0; i < 254; i++) push(16'h0001, 1'b0);
    checks++; if (bus.inReady !== 1'b1 || bus.divStart !== 1'b0) $display("FAIL forced_not_early got inReady=%b divStart=%b want 1 0", bus.inReady, bus.divStart); else passed++;
    push(16'h0001, 1'b0);
    wait_div(lat);
    checks++; if (lat !== 0) $display("FAIL forced_latency got %0d want 0", lat); else passed++;
    checks++; if (bus.divAcc !== 16'h00FF) $display("FAIL forced_divAcc got %h want 00FF", bus.divAcc); else passed++;
    checks++; if (bus.divDenom !== 8'd255) $display("FAIL forced_divDenom got %0d want 255", bus.divDenom); else passed++;
    @(negedge clk);
    div_done(16'h0001);
    checks++; if (bus.outForced !== 1'b1) $display("FAIL forced_outForced got %b want 1", bus.outForced); else passed++;
    checks++; if (bus.outData !== 16'h0001) $display("FAIL forced_outData got %h want 0001", bus.outData); else passed++;
    handshake();
    $display("test_forced done");
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    push(16'h0010, 1'b0);
    push(16'h0030, 1'b1);
    wait_div(lat);
    checks++; if (bus.divAcc !== 16'h0040) $display("FAIL bp_divAcc got %h want 0040", bus.divAcc); else passed++;
    @(negedge clk);
    div_done(16'h0020);
    bus.inValid = 1'b1;
    bus.inData  = 16'h0005;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.outData !== 16'h0020 || bus.inReady !== 1'b0 || bus.outValid !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else passed++;
    bus.inValid = 1'b0;
    handshake();
    checks++; if (bus.inReady !== 1'b1) $display("FAIL bp_inReady_after got %b want 1", bus.inReady); else passed++;
    push(16'h0005, 1'b0);
    push(16'h0007, 1'b1);
    wait_div(lat);
    checks++; if (lat !== 0 || bus.divAcc !== 16'h000C) $display("FAIL bp_next_group got lat=%0d divAcc=%h want 0 000C", lat, bus.divAcc); else passed++;
    @(negedge clk);
    div_done(16'h0006);
    handshake();
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    int lat;
    push(16'h1000, 1'b0);
    push(16'h1000, 1'b1);
    wait_div(lat);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.inReady !== 1'b1) $display("FAIL mid_inReady got %b want 1", bus.inReady); else passed++;
    checks++; if (bus.divAcc !== 16'h0 || bus.divDenom !== 8'h0) $display("FAIL mid_div_regs got %h %h want 0 0", bus.divAcc, bus.divDenom); else passed++;
    div_done(16'hBEEF);
    checks++; if (bus.outValid !== 1'b0 || bus.outData !== 16'h0) $display("FAIL mid_stale_done got valid=%b data=%h want 0 0000", bus.outValid, bus.outData); else passed++;
    push(16'h0400, 1'b1);
`ifdef KULISCH_MEAN_SEQ_BYPASS1_EN
    checks++; if (bus.outValid !== 1'b1 || bus.outData !== 16'h0400) $display("FAIL mid_next got valid=%b data=%h want 1 0400", bus.outValid, bus.outData); else passed++;
`else
    wait_div(lat);
    checks++; if (lat !== 0 || bus.divAcc !== 16'h0400 || bus.divDenom !== 8'd1) $display("FAIL mid_next_div got lat=%0d acc=%h den=%0d want 0 0400 1", lat, bus.divAcc, bus.divDenom); else passed++;
    @(negedge clk);
    div_done(16'h0400);
    checks++; if (bus.outValid !== 1'b1 || bus.outData !== 16'h0400) $display("FAIL mid_next got valid=%b data=%h want 1 0400", bus.outValid, bus.outData); else passed++;
`endif
    handshake();
    $display("test_reset_mid done");
  endtask

  task automatic test_single();
`ifdef KULISCH_MEAN_SEQ_BYPASS1_EN
    push(16'h0123, 1'b1);
    checks++; if (bus.outValid !== 1'b1) $display("FAIL single_outValid got %b want 1", bus.outValid); else passed++;
    checks++; if (bus.outData !== 16'h0123) $display("FAIL single_outData got %h want 0123", bus.outData); else passed++;
    checks++; if (bus.divStart !== 1'b0) $display("FAIL single_divStart got %b want 0", bus.divStart); else passed++;
    handshake();
    checks++; if (bus.divStart !== 1'b0 || bus.inReady !== 1'b1) $display("FAIL single_after got divStart=%b inReady=%b want 0 1", bus.divStart, bus.inReady); else passed++;
`else
    int lat;
    push(16'h0123, 1'b1);
    wait_div(lat);
    checks++; if (lat !== 0) $display("FAIL single_divStart got lat %0d want 0", lat); else passed++;
    checks++; if (bus.divDenom !== 8'd1) $display("FAIL single_divDenom got %0d want 1", bus.divDenom); else passed++;
    checks++; if (bus.divAcc !== 16'h0123) $display("FAIL single_divAcc got %h want 0123", bus.divAcc); else passed++;
    @(negedge clk);
    div_done(16'h0123);
    checks++; if (bus.outData !== 16'h0123 || bus.outForced !== 1'b0) $display("FAIL single_out got data=%h forced=%b want 0123 0", bus.outData, bus.outForced); else passed++;
    handshake();
`endif
    $display("test_single done");
  endtask

  initial begin
    rst           = 1'b1;
    bus.inValid   = 1'b0;
    bus.inData    = '0;
    bus.inLast    = 1'b0;
    bus.divDone   = 1'b0;
    bus.divResult = '0;
    bus.outReady  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_signed_wrap();
    test_forced();
    test_backpressure();
    test_reset_mid();
    test_single();
    checks++; if (push_timeouts !== 0) $display("FAIL push_timeouts got %0d want 0", push_timeouts); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
